// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Synchronises, debounces and qualifies the main button, the right
//             button and the six-button membrane pad. Produces clean levels,
//             per-channel press-event pulses and long-hold flags, all counted
//             in timebase (1 ms) ticks.
//  Revision : 1.0  initial release
// ============================================================================
module input_conditioner #(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int HOLD_TICKS     = 1000,
  parameter int N_MB           = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            timebase,
  input  logic            btn_raw,
  input  logic            btn_r_raw,
  input  logic [N_MB-1:0] mb_raw,
  output logic            button,
  output logic            button_r,
  output logic [N_MB-1:0] mbuttons,
  output logic            mb_conflict,
  output logic [N_MB+1:0] press_evt,
  output logic [N_MB+1:0] hold_long
);

  localparam int c_NCH = N_MB + 2;
  localparam int c_DW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int c_HW  = $clog2(HOLD_TICKS + 1);
  localparam int c_PW  = $clog2(N_MB + 1);

  localparam logic [c_DW-1:0] c_DCNT_MAX = c_DW'(DEBOUNCE_TICKS - 1);
  localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(HOLD_TICKS);

  typedef enum logic [1:0] {
    ST_LO     = 2'd0,
    ST_CHK_HI = 2'd1,
    ST_HI     = 2'd2,
    ST_CHK_LO = 2'd3
  } state_t;

  logic [c_NCH-1:0] w_raw;
  logic [c_NCH-1:0] w_level;
  logic [c_NCH-1:0] w_hold;

  assign w_raw = {mb_raw, btn_r_raw, btn_raw};

  for (genvar g = 0; g < c_NCH; g++) begin : g_ch
    logic [1:0]      sync_q;
    logic            w_s;
    state_t          state_q, state_d;
    logic [c_DW-1:0] dcnt_q, dcnt_d;
    logic            level_q, level_d;
    logic [c_HW-1:0] hcnt_q, hcnt_d;

    assign w_s = sync_q[1];

    // Two-stage synchroniser for the asynchronous raw input
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_q <= 2'b00;
      else       sync_q <= {sync_q[0], w_raw[g]};
    end

    // Debounce state, counter and level registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_LO;
        dcnt_q  <= '0;
        level_q <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        level_q <= level_d;
      end
    end

    // Debounce next-state: a disagreeing sample arms a check, which must then
    // survive DEBOUNCE_TICKS strobes; any agreeing sample cancels it first.
    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      level_d = level_q;
      case (state_q)
        ST_LO: begin
          if (w_s) begin
            state_d = ST_CHK_HI;
            dcnt_d  = '0;
          end
        end
        ST_CHK_HI: begin
          if (!w_s) begin
            state_d = ST_LO;
          end else if (timebase) begin
            if (dcnt_q == c_DCNT_MAX) begin
              state_d = ST_HI;
              level_d = 1'b1;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        ST_HI: begin
          if (!w_s) begin
            state_d = ST_CHK_LO;
            dcnt_d  = '0;
          end
        end
        ST_CHK_LO: begin
          if (w_s) begin
            state_d = ST_HI;
          end else if (timebase) begin
            if (dcnt_q == c_DCNT_MAX) begin
              state_d = ST_LO;
              level_d = 1'b0;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_LO;
      endcase
    end

    // Hold counter: cleared while released, saturates at HOLD_TICKS
    always_comb begin
      hcnt_d = hcnt_q;
      if (!level_q)
        hcnt_d = '0;
      else if (timebase && (hcnt_q != c_HOLD_MAX))
        hcnt_d = hcnt_q + 1'b1;
    end

    // Hold counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) hcnt_q <= '0;
      else       hcnt_q <= hcnt_d;
    end

    assign w_level[g] = level_q;
    // Gated with level so the flag drops together with the level output.
    assign w_hold[g]  = level_q & (hcnt_q == c_HOLD_MAX);
  end

  logic [c_PW-1:0]  w_mb_pop;
  logic             w_conflict;
  logic [c_NCH-1:0] w_rise;
  logic [c_NCH-1:0] lvl_q;
  logic             conflict_q;
  logic [N_MB-1:0]  mbtn_q;
  logic [c_NCH-1:0] evt_q;
  logic [c_NCH-1:0] hold_q;

  // Membrane popcount and conflict / rising-edge qualification
  always_comb begin
    w_mb_pop = '0;
    for (int i = 2; i < c_NCH; i++)
      w_mb_pop = w_mb_pop + c_PW'(w_level[i]);
    w_conflict = (w_mb_pop >= c_PW'(2));
    // lvl_q holds the previously presented level, so this is a one-clk edge.
    w_rise = w_level & ~lvl_q & {{N_MB{~w_conflict}}, 2'b11};
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q      <= '0;
      conflict_q <= 1'b0;
      mbtn_q     <= '0;
      evt_q      <= '0;
      hold_q     <= '0;
    end else begin
      lvl_q      <= w_level;
      conflict_q <= w_conflict;
      mbtn_q     <= w_conflict ? '0 : w_level[c_NCH-1:2];
      evt_q      <= w_rise;
      hold_q     <= w_hold;
    end
  end

  assign button      = lvl_q[0];
  assign button_r    = lvl_q[1];
  assign mbuttons    = mbtn_q;
  assign mb_conflict = conflict_q;
  assign press_evt   = evt_q;
  assign hold_long   = hold_q;

endmodule
`default_nettype wire
